// File: rtl/pll_lock_reset_seq.sv
// PLL bring-up sequencer: pulses the PLL reset, qualifies lock, then releases the
// core, MAC and PHY-interface resets in order. Everything runs on refclk.
module pll_lock_reset_seq #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 64
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    output logic       pll_rst,
    output logic [2:0] rst_stage,
    output logic       ready,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] retry_cnt
);

    localparam int unsigned MaxAB  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                     PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int unsigned MaxCD  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                                     LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int unsigned MaxCnt = (MaxAB > MaxCD) ? MaxAB : MaxCD;
    // The shared counter only ever holds a terminal value of (parameter - 1).
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast     = CntW'(STAGE_GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        StPllReset = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4
    } state_e;

    logic            sync1_q, sync1_d;
    logic            lock_s_q, lock_s_d;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pll_rst_q, pll_rst_d;
    logic [2:0]      rst_stage_q, rst_stage_d;
    logic            ready_q, ready_d;
    logic [7:0]      loss_q, loss_d;
    logic [7:0]      retry_q, retry_d;

    always_comb begin
        sync1_d     = locked_in;
        lock_s_d    = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        pll_rst_d   = pll_rst_q;
        rst_stage_d = rst_stage_q;
        ready_d     = ready_q;
        loss_d      = loss_q;
        retry_d     = retry_q;

        unique case (state_q)
            StPllReset: begin
                if (cnt_q == PllRstLast) begin
                    state_d   = StWaitLock;
                    cnt_d     = '0;
                    pll_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StWaitLock: begin
                // Lock wins over a timeout landing on the same cycle.
                if (lock_s_q) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d   = StPllReset;
                    cnt_d     = '0;
                    pll_rst_d = 1'b1;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StStable: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d     = StRelease;
                    cnt_d       = '0;
                    rst_stage_d = 3'b110;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end

            StRelease, StRun: begin
                if (!lock_s_q) begin
                    state_d     = StWaitLock;
                    cnt_d       = '0;
                    rst_stage_d = 3'b111;
                    ready_d     = 1'b0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end else if (state_q == StRelease) begin
                    if (cnt_q == GapLast) begin
                        cnt_d = '0;
                        // Bit 1 still asserted means the MAC stage is next.
                        if (rst_stage_q[1]) begin
                            rst_stage_d = 3'b100;
                        end else begin
                            rst_stage_d = 3'b000;
                            state_d     = StRun;
                            ready_d     = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end

            default: begin
                state_d     = StPllReset;
                cnt_d       = '0;
                pll_rst_d   = 1'b1;
                rst_stage_d = 3'b111;
                ready_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= StPllReset;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b1;
            rst_stage_q <= 3'b111;
            ready_q     <= 1'b0;
            loss_q      <= 8'd0;
            retry_q     <= 8'd0;
        end else begin
            sync1_q     <= sync1_d;
            lock_s_q    <= lock_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            rst_stage_q <= rst_stage_d;
            ready_q     <= ready_d;
            loss_q      <= loss_d;
            retry_q     <= retry_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign rst_stage     = rst_stage_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_q;
    assign retry_cnt     = retry_q;

endmodule

// File: doc/pll_lock_reset_seq.md
PLL_LOCK_RESET_SEQ -- requirements
Module: pll_lock_reset_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: number of cycles pll_rst is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1000000: maximum cycles spent waiting for lock before the PLL is reset again (20 ms at 50 MHz).
REQ-003 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before any reset release.
REQ-004 SHALL have parameter STAGE_GAP_CYCLES, default 64: cycles between successive reset-stage releases.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock, the 50 MHz board reference; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port locked_in, input, 1 bit: PLL locked, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1 bit: active-high reset to the PLL rst input.
REQ-009 SHALL have port rst_stage, output, 3 bits: active-high downstream resets, released in order bit0 (core), bit1 (MAC), bit2 (PHY interface).
REQ-010 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-011 SHALL have port state, output, 3 bits: encodes PLL_RESET=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
REQ-012 SHALL have port lock_loss_cnt, output, 8 bits: count of lock losses from RELEASE or RUN, saturating at 255.
REQ-013 SHALL have port retry_cnt, output, 8 bits: count of WAIT_LOCK timeouts, saturating at 255.

Function
REQ-014 SHALL pass locked_in through a 2-flop synchronizer to produce lock_s; an input change is visible in lock_s 2 cycles later, and the FSM acts on lock_s only.
REQ-015 SHALL in PLL_RESET drive pll_rst=1 and rst_stage=3'b111 for exactly PLL_RST_CYCLES cycles, then enter WAIT_LOCK; lock_s is ignored in this state.
REQ-016 SHALL in WAIT_LOCK drive pll_rst=0 and rst_stage=3'b111, and count cycles from 0.
REQ-017 SHALL in WAIT_LOCK enter STABLE on lock_s=1.
REQ-018 SHALL in WAIT_LOCK enter PLL_RESET and increment retry_cnt when the count reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0.
REQ-019 SHALL give lock_s=1 priority when lock_s=1 and timeout occur in the same cycle.
REQ-020 SHALL in STABLE keep rst_stage=3'b111 and count consecutive lock_s=1 cycles; enter RELEASE when the count reaches LOCK_STABLE_CYCLES.
REQ-021 SHALL on any lock_s=0 in STABLE return to WAIT_LOCK with the timeout count restarted at 0 and no counter increment.
REQ-022 SHALL in RELEASE clear rst_stage[0] in the first RELEASE cycle, clear rst_stage[1] STAGE_GAP_CYCLES cycles later, clear rst_stage[2] a further STAGE_GAP_CYCLES later, and enter RUN in the same cycle rst_stage[2] clears.
REQ-023 SHALL in RUN hold rst_stage=3'b000 and ready=1.
REQ-024 SHALL on lock_s=0 in RELEASE or RUN drive rst_stage=3'b111 and ready=0 on the next edge, increment lock_loss_cnt (saturating), and enter WAIT_LOCK; pll_rst is not pulsed.
REQ-025 SHALL register all outputs, with no combinational path from any input to any output.
REQ-026 SHALL make internal counters wide enough for their parameter (clog2), with no wrap-around before a terminal count.
REQ-027 SHALL hold lock_loss_cnt and retry_cnt at 255 once saturated; they clear only on rst.

Reset
REQ-028 SHALL on rst=1 at a rising edge set state=PLL_RESET, pll_rst=1, rst_stage=3'b111, ready=0, both counters 0, synchronizer flops 0, and all internal counts 0.
REQ-029 SHALL restart the PLL_RST_CYCLES count on the first edge with rst=0.
REQ-030 SHALL override every state with rst asserted mid-operation, including RUN and RELEASE.

Verification (bench parameters PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=4)
REQ-031 SHALL cover clean bring-up: rst 1->0, locked_in=1 from cycle 0 -> pll_rst high 4 cycles; 8 stable cycles later rst_stage goes 110, then 100 4 cycles later, then 000 4 cycles later; ready=1, state=4.
REQ-032 SHALL cover timeout: locked_in held 0 -> pll_rst re-pulses every 104 cycles; retry_cnt increments each time and stays at 255 after 255+ timeouts.
REQ-033 SHALL cover glitch in STABLE: locked_in low 1 cycle after 5 stable cycles -> state 1, rst_stage stays 111, no counter change, full 8 cycles needed again.
REQ-034 SHALL cover lock loss in RUN: locked_in 1->0 -> 3 cycles later rst_stage=111 and ready=0; lock_loss_cnt=1, state=1, pll_rst stays 0.
REQ-035 SHALL cover mid-RELEASE loss and reset: lock drop after the bit0 release -> rst_stage=111 and lock_loss_cnt +1; later rst asserted in RUN -> next edge all outputs at reset values.
REQ-036 SHALL cover simultaneous lock and timeout: lock_s rises on timeout cycle 99 -> STABLE entered, retry_cnt unchanged.
